// File: rtl/calc_pkg.sv
// Shared key codes, opcode encodings and controller states for the calculator entry path.
package calc_pkg;

  localparam logic [3:0] KEY_DIG_MAX = 4'd9;
  localparam logic [3:0] KEY_ADD     = 4'd10;
  localparam logic [3:0] KEY_SUB     = 4'd11;
  localparam logic [3:0] KEY_MUL     = 4'd12;
  localparam logic [3:0] KEY_DIV     = 4'd13;
  localparam logic [3:0] KEY_EQ      = 4'd14;
  localparam logic [3:0] KEY_CLR     = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_EXEC,
    S_DONE,
    S_ERR
  } state_t;

  // Map an operator key onto the ALU opcode field.
  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    logic [1:0] op;
    case (key)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: acc <= acc*10 + digit, saturating at MAX_DIGITS digits.
module calc_digit_accum #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_add,
  input  logic [3:0]        i_digit,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_full
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_scaled;
  logic [DATA_W-1:0] w_next;
  logic              w_full;

  assign w_full   = (r_cnt >= CNT_W'(MAX_DIGITS));
  assign w_scaled = r_acc * DATA_W'(10);
  assign w_next   = w_scaled + DATA_W'(i_digit);

  // Clear wins over load, load wins over accumulate; a digit past the limit is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= DATA_W'(i_digit);
      r_cnt <= CNT_W'(1);
    end else if (i_add && !w_full) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_full = w_full;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU entry sequencer: builds operands, pulses latch enables, runs the ALU handshake.
// Optional ALU ack timeout is enabled with `define CALC_ALU_TIMEOUT_EN.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_DIGITS  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              key_ready,
  output logic [DATA_W-1:0] opd_data,
  output logic              lat_en_a,
  output logic              lat_en_b,
  output logic              lat_en_op,
  output logic [1:0]        op_code,
  output logic              alu_req,
  input  logic              alu_ack,
  input  logic              alu_err,
  output logic              busy,
  output logic              err
);

  state_t      r_state;
  logic        r_key_ready;
  logic        r_en_a;
  logic        r_en_b;
  logic        r_en_op;
  logic [1:0]  r_op_code;
  logic        r_alu_req;
  logic        r_busy;
  logic        r_err;

  logic        w_accept;
  logic        w_is_digit;
  logic        w_is_op;
  logic        w_is_eq;
  logic        w_is_clr;
  logic        w_acc_clr;
  logic        w_acc_load;
  logic        w_acc_add;
  logic        w_acc_full;

`ifdef CALC_ALU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYC;
`endif

  assign w_accept   = key_valid & r_key_ready;
  assign w_is_digit = (key_code <= KEY_DIG_MAX);
  assign w_is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign w_is_eq    = (key_code == KEY_EQ);
  assign w_is_clr   = (key_code == KEY_CLR);

  // Accumulator commands follow the same accept decode as the state machine below.
  assign w_acc_clr  = w_accept & ((w_is_clr & (r_state != S_EXEC)) | (w_is_op & (r_state == S_A)));
  assign w_acc_load = w_accept & w_is_digit & (r_state == S_DONE);
  assign w_acc_add  = w_accept & w_is_digit &
                      ((r_state == S_A) | (r_state == S_OP) | (r_state == S_B));

  calc_digit_accum #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_accum (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_acc_clr),
    .i_load  (w_acc_load),
    .i_add   (w_acc_add),
    .i_digit (key_code),
    .o_acc   (opd_data),
    .o_full  (w_acc_full)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_A;
      r_key_ready <= 1'b1;
      r_en_a      <= 1'b0;
      r_en_b      <= 1'b0;
      r_en_op     <= 1'b0;
      r_op_code   <= OP_ADD;
      r_alu_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_en_a  <= 1'b0;
      r_en_b  <= 1'b0;
      r_en_op <= 1'b0;
      // Clear is never accepted in S_EXEC because key_ready is low there.
      if (w_accept && w_is_clr) begin
        r_state   <= S_A;
        r_op_code <= OP_ADD;
        r_en_a    <= 1'b1;
        r_err     <= 1'b0;
      end else begin
        case (r_state)
          S_A: begin
            if (w_accept && w_is_digit) begin
              r_en_a <= !w_acc_full;
            end else if (w_accept && w_is_op) begin
              r_op_code <= key_to_op(key_code);
              r_en_op   <= 1'b1;
              r_state   <= S_OP;
            end
          end
          S_OP: begin
            if (w_accept && w_is_digit) begin
              r_en_b  <= 1'b1;
              r_state <= S_B;
            end else if (w_accept && w_is_op) begin
              r_op_code <= key_to_op(key_code);
              r_en_op   <= 1'b1;
            end
          end
          S_B: begin
            if (w_accept && w_is_digit) begin
              r_en_b <= !w_acc_full;
            end else if (w_accept && w_is_eq) begin
              r_alu_req   <= 1'b1;
              r_busy      <= 1'b1;
              r_key_ready <= 1'b0;
              r_state     <= S_EXEC;
`ifdef CALC_ALU_TIMEOUT_EN
              r_to_cnt    <= '0;
`endif
            end
          end
          S_EXEC: begin
            // An ack on the expiry cycle takes priority over the timeout.
            if (alu_ack) begin
              r_alu_req   <= 1'b0;
              r_busy      <= 1'b0;
              r_key_ready <= 1'b1;
              r_err       <= alu_err;
              r_state     <= alu_err ? S_ERR : S_DONE;
            end
`ifdef CALC_ALU_TIMEOUT_EN
            else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
              r_alu_req   <= 1'b0;
              r_busy      <= 1'b0;
              r_key_ready <= 1'b1;
              r_err       <= 1'b1;
              r_state     <= S_ERR;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
`endif
          end
          S_DONE: begin
            if (w_accept && w_is_digit) begin
              r_en_a  <= 1'b1;
              r_state <= S_A;
            end
          end
          S_ERR: begin
          end
          default: r_state <= S_A;
        endcase
      end
    end
  end

  assign key_ready = r_key_ready;
  assign lat_en_a  = r_en_a;
  assign lat_en_b  = r_en_b;
  assign lat_en_op = r_en_op;
  assign op_code   = r_op_code;
  assign alu_req   = r_alu_req;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed vector bench for calc_entry_ctrl; honours `define CALC_ALU_TIMEOUT_EN.
module tb_calc_entry_ctrl;

`ifdef CALC_ALU_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        alu_ack = 1'b0;
  logic        alu_err = 1'b0;
  logic        key_ready;
  logic [15:0] opd_data;
  logic        lat_en_a;
  logic        lat_en_b;
  logic        lat_en_op;
  logic [1:0]  op_code;
  logic        alu_req;
  logic        busy;
  logic        err;

  calc_entry_ctrl #(
    .DATA_W      (16),
    .MAX_DIGITS  (4),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .opd_data  (opd_data),
    .lat_en_a  (lat_en_a),
    .lat_en_b  (lat_en_b),
    .lat_en_op (lat_en_op),
    .op_code   (op_code),
    .alu_req   (alu_req),
    .alu_ack   (alu_ack),
    .alu_err   (alu_err),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [15:0] opd;
    logic        en_a;
    logic        en_b;
    logic        en_op;
    logic [1:0]  oc;
    logic        req;
    logic        busy;
    logic        err;
  } out_t;

  typedef struct {
    string      name;
    logic       v;
    logic [3:0] k;
    logic       ack;
    logic       aerr;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  out_t got;

  assign got = {key_ready, opd_data, lat_en_a, lat_en_b, lat_en_op, op_code, alu_req, busy, err};

  function automatic out_t mk(int rdy, int opd, int a, int b, int o, int oc,
                              int req, int bsy, int er);
    out_t r;
    r.rdy   = rdy[0];
    r.opd   = 16'(opd);
    r.en_a  = a[0];
    r.en_b  = b[0];
    r.en_op = o[0];
    r.oc    = 2'(oc);
    r.req   = req[0];
    r.busy  = bsy[0];
    r.err   = er[0];
    return r;
  endfunction

  task automatic add(string n, int v, int k, int ack, int aerr, out_t e);
    vec_t t;
    t.name = n;
    t.v    = v[0];
    t.k    = 4'(k);
    t.ack  = ack[0];
    t.aerr = aerr[0];
    t.exp  = e;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, let the edge happen, leave outputs settled for checking.
  task automatic step(int v, int k, int ack, int aerr);
    key_valid = v[0];
    key_code  = 4'(k);
    alu_ack   = ack[0];
    alu_err   = aerr[0];
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    alu_ack   = 1'b0;
    alu_err   = 1'b0;
  endtask

  task automatic check(string n, out_t e);
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL %s: got rdy=%b opd=%0d en_a/b/op=%b%b%b oc=%b req=%b busy=%b err=%b ; want rdy=%b opd=%0d en_a/b/op=%b%b%b oc=%b req=%b busy=%b err=%b",
               n, got.rdy, got.opd, got.en_a, got.en_b, got.en_op, got.oc, got.req, got.busy, got.err,
               e.rdy, e.opd, e.en_a, e.en_b, e.en_op, e.oc, e.req, e.busy, e.err);
    end
  endtask

  initial begin
    //      name       v  key ack aerr   rdy opd  a  b  op oc req bsy err
    add("d1",         1,  1, 0, 0, mk(1,    1, 1, 0, 0, 0, 0, 0, 0));
    add("d2",         1,  2, 0, 0, mk(1,   12, 1, 0, 0, 0, 0, 0, 0));
    add("plus",       1, 10, 0, 0, mk(1,    0, 0, 0, 1, 0, 0, 0, 0));
    add("b3",         1,  3, 0, 0, mk(1,    3, 0, 1, 0, 0, 0, 0, 0));
    add("eq",         1, 14, 0, 0, mk(0,    3, 0, 0, 0, 0, 1, 1, 0));
    add("exec_w1",    1,  5, 0, 0, mk(0,    3, 0, 0, 0, 0, 1, 1, 0));
    add("exec_w2",    0,  0, 0, 0, mk(0,    3, 0, 0, 0, 0, 1, 1, 0));
    add("ack_ok",     0,  0, 1, 0, mk(1,    3, 0, 0, 0, 0, 0, 0, 0));
    add("done_mul",   1, 12, 0, 0, mk(1,    3, 0, 0, 0, 0, 0, 0, 0));
    add("done_eq",    1, 14, 0, 0, mk(1,    3, 0, 0, 0, 0, 0, 0, 0));
    add("done_d9",    1,  9, 0, 0, mk(1,    9, 1, 0, 0, 0, 0, 0, 0));
    add("a_d8",       1,  8, 0, 0, mk(1,   98, 1, 0, 0, 0, 0, 0, 0));
    add("a_d7",       1,  7, 0, 0, mk(1,  987, 1, 0, 0, 0, 0, 0, 0));
    add("a_d6",       1,  6, 0, 0, mk(1, 9876, 1, 0, 0, 0, 0, 0, 0));
    add("a_d5_sat",   1,  5, 0, 0, mk(1, 9876, 0, 0, 0, 0, 0, 0, 0));
    add("a_eq_ign",   1, 14, 0, 0, mk(1, 9876, 0, 0, 0, 0, 0, 0, 0));
    add("a_ack_ign",  0,  0, 1, 1, mk(1, 9876, 0, 0, 0, 0, 0, 0, 0));
    add("op_plus",    1, 10, 0, 0, mk(1,    0, 0, 0, 1, 0, 0, 0, 0));
    add("op_mul",     1, 12, 0, 0, mk(1,    0, 0, 0, 1, 2, 0, 0, 0));
    add("op_eq_ign",  1, 14, 0, 0, mk(1,    0, 0, 0, 0, 2, 0, 0, 0));
    add("op_idle",    0,  5, 0, 0, mk(1,    0, 0, 0, 0, 2, 0, 0, 0));
    add("b_d4",       1,  4, 0, 0, mk(1,    4, 0, 1, 0, 2, 0, 0, 0));
    add("b_sub_ign",  1, 11, 0, 0, mk(1,    4, 0, 0, 0, 2, 0, 0, 0));
    add("b_d5",       1,  5, 0, 0, mk(1,   45, 0, 1, 0, 2, 0, 0, 0));
    add("b_clr",      1, 15, 0, 0, mk(1,    0, 1, 0, 0, 0, 0, 0, 0));
    add("e_d7",       1,  7, 0, 0, mk(1,    7, 1, 0, 0, 0, 0, 0, 0));
    add("e_div",      1, 13, 0, 0, mk(1,    0, 0, 0, 1, 3, 0, 0, 0));
    add("e_d0",       1,  0, 0, 0, mk(1,    0, 0, 1, 0, 3, 0, 0, 0));
    add("e_eq",       1, 14, 0, 0, mk(0,    0, 0, 0, 0, 3, 1, 1, 0));
    add("e_ack_err",  0,  0, 1, 1, mk(1,    0, 0, 0, 0, 3, 0, 0, 1));
    add("e_d5_drop",  1,  5, 0, 0, mk(1,    0, 0, 0, 0, 3, 0, 0, 1));
    add("e_eq_drop",  1, 14, 0, 0, mk(1,    0, 0, 0, 0, 3, 0, 0, 1));
    add("e_clr",      1, 15, 0, 0, mk(1,    0, 1, 0, 0, 0, 0, 0, 0));

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    rstn = 1'b1;

    foreach (vecs[i]) begin
      step(int'(vecs[i].v), int'(vecs[i].k), int'(vecs[i].ack), int'(vecs[i].aerr));
      check(vecs[i].name, vecs[i].exp);
    end

    // Reset while the ALU request is outstanding; a late ack must be ignored.
    step(1, 1, 0, 0);
    step(1, 10, 0, 0);
    step(1, 2, 0, 0);
    step(1, 14, 0, 0);
    check("rx_exec", mk(0, 2, 0, 0, 0, 0, 1, 1, 0));
    step(0, 0, 0, 0);
    rstn = 1'b0;
    step(0, 0, 0, 0);
    check("rx_reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    rstn = 1'b1;
    step(0, 0, 1, 0);
    check("rx_late_ack", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 4, 0, 0);
    check("rx_d4", mk(1, 4, 1, 0, 0, 0, 0, 0, 0));

    // No ack at all: timeout path or indefinite wait depending on build.
    step(1, 10, 0, 0);
    step(1, 2, 0, 0);
    step(1, 14, 0, 0);
    check("to_rise", mk(0, 2, 0, 0, 0, 0, 1, 1, 0));
`ifdef CALC_ALU_TIMEOUT_EN
    for (int c = 1; c < 4; c++) begin
      step(0, 0, 0, 0);
      check($sformatf("to_wait%0d", c), mk(0, 2, 0, 0, 0, 0, 1, 1, 0));
    end
    step(0, 0, 0, 0);
    check("to_expire", mk(1, 2, 0, 0, 0, 0, 0, 0, 1));
    step(1, 15, 0, 0);
    check("to_clr", mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
`else
    repeat (100) step(0, 0, 0, 0);
    check("to_still_busy", mk(0, 2, 0, 0, 0, 0, 1, 1, 0));
    step(0, 0, 1, 0);
    check("to_late_ack", mk(1, 2, 0, 0, 0, 0, 0, 0, 0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
